// File: rtl/pulse_hold.sv
// ============================================================================
// Module   : pulse_hold
// Purpose  : Rebuilds a held level from a stream of single-cycle pulses and
//            reports the pulse count of each burst. State updates on negedge.
// Options  : PULSE_HOLD_LONG_PRESS_EN enables the o_Long long-press flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_hold #(
    parameter int TIMEOUT_CYCLES = 100,
    parameter int COUNT_WIDTH    = 8,
    parameter int LONG_COUNT     = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Pulse,
    output logic                   o_Level,
    output logic [COUNT_WIDTH-1:0] o_Count,
    output logic                   o_Done,
    output logic                   o_Long
);

    localparam int                     c_GAP_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_GAP_W-1:0]     c_GAP_LAST  = c_GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = COUNT_WIDTH'(1);

    // Elaboration-time guards on the legal parameter ranges.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("pulse_hold: TIMEOUT_CYCLES must be >= 1");
    end
    if (COUNT_WIDTH < 2) begin : g_bad_width
        $error("pulse_hold: COUNT_WIDTH must be >= 2");
    end
    if ((LONG_COUNT < 1) ||
        (longint'(LONG_COUNT) > ((longint'(1) << COUNT_WIDTH) - 1))) begin : g_bad_long
        $error("pulse_hold: LONG_COUNT out of range");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_GAP_W-1:0]     r_gap;
    logic [c_GAP_W-1:0]     w_gap_nxt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic                   r_done;
    logic                   w_done_nxt;

    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Pulse) begin
                    w_state_nxt = ST_ACTIVE;
                    w_gap_nxt   = '0;
                    w_count_nxt = c_COUNT_ONE;
                end
            end
            ST_ACTIVE: begin
                // A pulse on the would-be timeout edge keeps the burst alive.
                if (i_Pulse) begin
                    w_gap_nxt = '0;
                    if (r_count != c_COUNT_MAX) begin
                        w_count_nxt = r_count + c_COUNT_ONE;
                    end
                end else if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_gap_nxt = r_gap + c_GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_Level = (r_state == ST_ACTIVE);
    assign o_Count = r_count;
    assign o_Done  = r_done;

`ifdef PULSE_HOLD_LONG_PRESS_EN
    localparam logic [COUNT_WIDTH-1:0] c_LONG = COUNT_WIDTH'(LONG_COUNT);

    logic r_long;
    logic w_long_nxt;

    // Sticky within a burst; clears on the same edge the level falls.
    always_comb begin
        w_long_nxt = (w_state_nxt == ST_ACTIVE) && (r_long || (w_count_nxt == c_LONG));
    end

    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            r_long <= 1'b0;
        end else begin
            r_long <= w_long_nxt;
        end
    end

    assign o_Long = r_long;
`else
    assign o_Long = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_hold.sv
// Testbench for pulse_hold: directed scenarios plus randomized pulse streams
// compared against a burst-level reference model.
`default_nettype none

module tb_pulse_hold;

    localparam int TIMEOUT = 4;
    localparam int CW      = 3;
    localparam int LONG    = 3;
    localparam int CMAX    = (1 << CW) - 1;

    logic          i_Clk;
    logic          i_Rst;
    logic          i_Pulse;
    logic          o_Level;
    logic [CW-1:0] o_Count;
    logic          o_Done;
    logic          o_Long;

    pulse_hold #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .COUNT_WIDTH   (CW),
        .LONG_COUNT    (LONG)
    ) u_dut (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Pulse(i_Pulse),
        .o_Level(o_Level),
        .o_Count(o_Count),
        .o_Done (o_Done),
        .o_Long (o_Long)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a burst is live from a pulse until TIMEOUT edges
    // pass with no pulse since the most recent one.
    bit      m_live = 1'b0;
    int      m_cnt  = 0;
    int      m_edge = 0;
    int      m_last = 0;
    logic          exp_level = 1'b0;
    logic          exp_done  = 1'b0;
    logic [CW-1:0] exp_count = '0;
    logic          exp_long  = 1'b0;

    task automatic tick(input logic p, input logic r);
        @(posedge i_Clk);
        #1;
        i_Pulse = p;
        i_Rst   = r;
        @(negedge i_Clk);
        #1;
        m_edge++;
        exp_done = 1'b0;
        if (r) begin
            m_live = 1'b0;
            m_cnt  = 0;
        end else if (p) begin
            m_cnt  = m_live ? ((m_cnt < CMAX) ? m_cnt + 1 : CMAX) : 1;
            m_live = 1'b1;
            m_last = m_edge;
        end else if (m_live && (m_edge - m_last) == TIMEOUT) begin
            m_live   = 1'b0;
            exp_done = 1'b1;
        end
        exp_level = m_live;
        exp_count = m_cnt[CW-1:0];
`ifdef PULSE_HOLD_LONG_PRESS_EN
        exp_long  = m_live && (m_cnt >= LONG);
`else
        exp_long  = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [5:0] got;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) tick(1'b0, 1'b0);
            got = {o_Level, o_Done, o_Count, o_Long};
            n_checks++;
            if (got !== 6'b0) $display("FAIL reset_state[%0d]: got %b want 000000", i, got);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [4:0] got, want;
        for (int e = 0; e < 6; e++) begin
            tick(e == 0, 1'b0);
            got  = {o_Level, o_Done, o_Count};
            want = {(e < 4) ? 1'b1 : 1'b0, (e == 4) ? 1'b1 : 1'b0, 3'd1};
            n_checks++;
            if (got !== want) $display("FAIL single_pulse[e%0d]: got %b want %b", e, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_burst5();
        logic [5:0] got, want;
        int c;
        for (int e = 0; e < 18; e++) begin
            tick((e % 3 == 0) && (e <= 12), 1'b0);
            c = (e / 3 + 1 > 5) ? 5 : e / 3 + 1;
            want[5]   = (e < 16);
            want[4]   = (e == 16);
            want[3:1] = c[2:0];
`ifdef PULSE_HOLD_LONG_PRESS_EN
            want[0]   = (c >= 3) && (e < 16);
`else
            want[0]   = 1'b0;
`endif
            got = {o_Level, o_Done, o_Count, o_Long};
            n_checks++;
            if (got !== want) $display("FAIL burst5[e%0d]: got %b want %b", e, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_boundary();
        int dones;
        int fin;
        for (int s = 4; s <= 5; s++) begin
            dones = 0;
            fin   = 0;
            for (int e = 0; e <= s + 5; e++) begin
                tick((e == 0) || (e == s), 1'b0);
                if (o_Done === 1'b1) begin
                    dones++;
                    fin = int'(o_Count);
                end
                n_checks++;
                if ({o_Level, o_Done, o_Count} !== {exp_level, exp_done, exp_count})
                    $display("FAIL boundary_s%0d[e%0d]: got %b%b%0d want %b%b%0d", s, e,
                             o_Level, o_Done, o_Count, exp_level, exp_done, exp_count);
                else n_pass++;
            end
            n_checks++;
            if (dones != ((s == 4) ? 1 : 2) || fin != ((s == 4) ? 2 : 1))
                $display("FAIL boundary_s%0d_bursts: got dones=%0d count=%0d want dones=%0d count=%0d",
                         s, dones, fin, (s == 4) ? 1 : 2, (s == 4) ? 2 : 1);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [4:0] got, want;
        int c;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            c    = (i + 1 > 7) ? 7 : i + 1;
            got  = {o_Level, o_Done, o_Count};
            want = {1'b1, 1'b0, c[2:0]};
            n_checks++;
            if (got !== want) $display("FAIL saturate_hold[%0d]: got %b want %b", i, got, want);
            else n_pass++;
        end
        for (int e = 1; e <= 5; e++) begin
            tick(1'b0, 1'b0);
            got  = {o_Level, o_Done, o_Count};
            want = {(e < 4) ? 1'b1 : 1'b0, (e == 4) ? 1'b1 : 1'b0, 3'd7};
            n_checks++;
            if (got !== want) $display("FAIL saturate_release[e%0d]: got %b want %b", e, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [5:0] got;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        n_checks++;
        if (o_Count !== 3'd3) $display("FAIL midrst_pre: got count %0d want 3", o_Count);
        else n_pass++;
        tick(1'b0, 1'b1);
        got = {o_Level, o_Done, o_Count, o_Long};
        n_checks++;
        if (got !== 6'b0) $display("FAIL midrst_clear: got %b want 000000", got);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            got = {o_Level, o_Done, o_Count, o_Long};
            n_checks++;
            if (got !== 6'b0) $display("FAIL midrst_quiet[%0d]: got %b want 000000", i, got);
            else n_pass++;
        end
        tick(1'b1, 1'b0);
        n_checks++;
        if ({o_Level, o_Count} !== {1'b1, 3'd1})
            $display("FAIL midrst_restart: got level=%b count=%0d want level=1 count=1", o_Level, o_Count);
        else n_pass++;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_long();
        logic [5:0] got, want;
        int c;
        for (int e = 0; e < 12; e++) begin
            tick((e % 2 == 0) && (e <= 6), 1'b0);
            c = (e / 2 + 1 > 4) ? 4 : e / 2 + 1;
            want[5]   = (e < 10);
            want[4]   = (e == 10);
            want[3:1] = c[2:0];
`ifdef PULSE_HOLD_LONG_PRESS_EN
            want[0]   = (c >= 3) && (e < 10);
`else
            want[0]   = 1'b0;
`endif
            got = {o_Level, o_Done, o_Count, o_Long};
            n_checks++;
            if (got !== want) $display("FAIL long_press[e%0d]: got %b want %b", e, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic p, r;
        int dens;
        for (int i = 0; i < 3000; i++) begin
            dens = ((i / 150) % 3 == 0) ? 8 : (((i / 150) % 3 == 1) ? 35 : 80);
            p = ($urandom_range(0, 99) < dens);
            r = ($urandom_range(0, 249) == 0);
            tick(p, r);
            n_checks++;
            if ({o_Level, o_Done, o_Count, o_Long} !== {exp_level, exp_done, exp_count, exp_long})
                $display("FAIL random[%0d]: got L%b D%b C%0d G%b want L%b D%b C%0d G%b", i,
                         o_Level, o_Done, o_Count, o_Long, exp_level, exp_done, exp_count, exp_long);
            else n_pass++;
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        i_Rst   = 1'b1;
        i_Pulse = 1'b0;
        test_reset();
        test_single();
        test_burst5();
        test_boundary();
        test_saturation();
        test_reset_mid_burst();
        test_long();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/pulse_hold.md
Name: pulse_hold

Overview:
- Inverse of the key pulse generator: rebuilds a held level from a stream of single-cycle pulses, such as the auto-repeat pulses produced for a held TM1638 key.
- Output is high from the first pulse of a burst until no pulse arrives for TIMEOUT_CYCLES cycles.
- Reports the pulse count of each burst and strobes completion when the burst ends.
- Sits between the key pulse stage and the application logic that needs "key held" and "press length".

Parameters:
- TIMEOUT_CYCLES, 100, gap in cycles without a pulse that ends a burst; legal range >= 1.
- COUNT_WIDTH, 8, width of the burst pulse counter; legal range >= 2.
- LONG_COUNT, 3, burst pulse count at which o_Long asserts (optional feature only); legal range 1..2^COUNT_WIDTH-1.

Ports:
- i_Clk  input  1  clock; all state updates on the negative edge.
- i_Rst  input  1  synchronous, active-high reset, sampled on the clock edge.
- i_Pulse  input  1  pulse stream; every edge that samples i_Pulse high counts as one pulse.
- o_Level  output  1  reconstructed level; high while a burst is active.
- o_Count  output  COUNT_WIDTH  pulse count of the current burst, or of the last completed burst.
- o_Done  output  1  one-cycle strobe on burst end.
- o_Long  output  1  long-press flag (optional feature).

Behaviour:
- All outputs are registered; there is no combinational path from input to output.
- Reset values: state IDLE, gap counter 0, o_Level 0, o_Count 0, o_Done 0, o_Long 0.
- Reset mid-burst aborts the burst silently: no o_Done is produced.
- States: IDLE and ACTIVE.
- IDLE, i_Pulse=1 at edge k:
  - go to ACTIVE; o_Level=1, o_Count=1, gap=0; o_Done=0.
  - Latency is one edge: o_Level is visible after edge k.
- IDLE, i_Pulse=0: hold o_Count at its last value; o_Done=0.
- ACTIVE, i_Pulse=1:
  - gap=0.
  - o_Count=o_Count+1, saturating at 2^COUNT_WIDTH-1 with no wrap-around.
- ACTIVE, i_Pulse=0, gap==TIMEOUT_CYCLES-1:
  - go to IDLE; o_Level=0; o_Done=1 for exactly one cycle.
  - o_Count retains the final burst count until the next burst starts.
- ACTIVE, i_Pulse=0, otherwise: gap=gap+1.
- Timing consequence: after a lone pulse at edge k, o_Level is high for edges k..k+TIMEOUT_CYCLES-1 and falls at edge k+TIMEOUT_CYCLES.
- Simultaneous events:
  - A pulse on the would-be timeout edge wins: the burst continues, gap=0 and the count increments.
  - A pulse on the edge after o_Done starts a new burst normally; o_Done drops, o_Count=1.
- i_Pulse held high continuously counts every cycle, so the burst never ends until the input falls.
- Gap counter width is clog2(TIMEOUT_CYCLES)+1; TIMEOUT_CYCLES=1 ends a burst on the first edge without a pulse.

Optional Feature:
- Macro PULSE_HOLD_LONG_PRESS_EN.
- Defined:
  - o_Long goes high on the edge where o_Count becomes LONG_COUNT and stays high while in ACTIVE.
  - o_Long clears on the same edge o_Level falls, or on reset.
  - LONG_COUNT=1 asserts o_Long together with o_Level.
- Undefined: o_Long is tied to 0 and no comparison logic is built; the port list is unchanged.

Test Plan:
- Single pulse, TIMEOUT_CYCLES=4, pulse sampled at edge 10 -> o_Level 1 on edges 10-13 and 0 at edge 14; o_Done=1 for edge 14 only; o_Count=1 afterwards.
- 5 pulses spaced 3 cycles, TIMEOUT_CYCLES=4 -> o_Level continuously high; o_Count steps 1..5; o_Done fires 4 edges after the last pulse with o_Count=5.
- Boundary spacing, TIMEOUT_CYCLES=4:
  - pulses 4 cycles apart -> one burst, count 2, one o_Done.
  - pulses 5 cycles apart -> two bursts, two o_Done strobes, count 1 each.
- Saturation, COUNT_WIDTH=3 -> i_Pulse held high 20 cycles gives o_Count=7 and no wrap; o_Done 4 edges after i_Pulse falls.
- Reset asserted mid-burst at count 3 -> next edge o_Level=0, o_Count=0, o_Long=0; no o_Done; a following pulse starts count at 1.
- Long press, LONG_COUNT=3, pulses spaced 2 cycles:
  - macro defined -> o_Long rises at the third pulse edge and falls with o_Level.
  - macro undefined -> o_Long stays 0 throughout.
